// File: rtl/trigger_sequencer.sv
// trigger_sequencer: multi-stage event trigger with post-trigger delay.
//
// Walks a programmable chain of stages. Each stage waits for N hits of an
// ANY/ALL combination of selected matcher events. After the final stage it
// counts a post-trigger delay in sample beats, then pulses trg_fire once.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   ctl_arm      start the sequence (accepted in IDLE/FIRED only)
//   ctl_abort    return to IDLE; overrides everything else
//   cfg_msk      per-stage event select, stage s = cfg_msk[s*MEW +: MEW]
//   cfg_and      per-stage combine: 1 = all selected, 0 = any selected
//   cfg_cnt      per-stage hits required minus one
//   cfg_lst      index of the final stage
//   cfg_dly      post-trigger delay in evt beats (0 = none)
//   evt_vld      sti_evt carries a sample beat this cycle
//   sti_evt      matcher event bits
//   sts_state    0 IDLE, 1 ARMED, 2 DELAY, 3 FIRED
//   sts_stage    current stage index
//   trg_fire     one-cycle trigger pulse
//
// cfg_* is not latched; it must be held stable while the sequencer is busy.
module trigger_sequencer #(
    parameter int MEW = 4,
    parameter int STN = 4,
    parameter int CNW = 16,
    localparam int SW = (STN > 1) ? $clog2(STN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctl_arm,
    input  logic               ctl_abort,
    input  logic [STN*MEW-1:0] cfg_msk,
    input  logic [STN-1:0]     cfg_and,
    input  logic [STN*CNW-1:0] cfg_cnt,
    input  logic [SW-1:0]      cfg_lst,
    input  logic [CNW-1:0]     cfg_dly,
    input  logic               evt_vld,
    input  logic [MEW-1:0]     sti_evt,
    output logic [1:0]         sts_state,
    output logic [SW-1:0]      sts_stage,
    output logic               trg_fire
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DELAY = 2'd2;
    localparam logic [1:0] S_FIRED = 2'd3;

    logic [1:0]     r_state;
    logic [SW-1:0]  r_stage;
    logic [CNW-1:0] r_hit;
    logic [CNW-1:0] r_dly;
    logic           r_fire;

    logic [MEW-1:0] w_msk;
    logic [MEW-1:0] w_sel;
    logic [CNW-1:0] w_cnt;
    logic           w_and;
    logic           w_hit;

    // Current stage's configuration slice.
    always_comb begin
        w_msk = cfg_msk[r_stage*MEW +: MEW];
        w_cnt = cfg_cnt[r_stage*CNW +: CNW];
        w_and = cfg_and[r_stage];
        w_sel = sti_evt & w_msk;
        // An empty mask makes the stage a plain beat counter.
        if (w_msk == '0) begin
            w_hit = 1'b1;
        end else if (w_and) begin
            w_hit = (w_sel == w_msk);
        end else begin
            w_hit = |w_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_hit   <= '0;
            r_dly   <= '0;
            r_fire  <= 1'b0;
        end else begin
            r_fire <= 1'b0;
            if (ctl_abort) begin
                r_state <= S_IDLE;
                r_stage <= '0;
                r_hit   <= '0;
                r_dly   <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_FIRED: begin
                        if (ctl_arm) begin
                            r_state <= S_ARMED;
                            r_stage <= '0;
                            r_hit   <= '0;
                            r_dly   <= '0;
                        end
                    end
                    S_ARMED: begin
                        // A non-hit beat holds the hit count.
                        if (evt_vld && w_hit) begin
                            if (r_hit != w_cnt) begin
                                r_hit <= r_hit + 1'b1;
                            end else if (r_stage != cfg_lst) begin
                                r_stage <= r_stage + 1'b1;
                                r_hit   <= '0;
                            end else if (cfg_dly == '0) begin
                                r_state <= S_FIRED;
                                r_hit   <= '0;
                                r_fire  <= 1'b1;
                            end else begin
                                r_state <= S_DELAY;
                                r_hit   <= '0;
                                r_dly   <= cfg_dly;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (evt_vld) begin
                            if (r_dly == {{(CNW-1){1'b0}}, 1'b1}) begin
                                r_state <= S_FIRED;
                                r_dly   <= '0;
                                r_fire  <= 1'b1;
                            end else begin
                                r_dly <= r_dly - 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sts_state = r_state;
    assign sts_stage = r_stage;
    assign trg_fire  = r_fire;

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: self-checking bench for trigger_sequencer.
// Expected fire edges are queued at stimulus time and matched by a monitor.
module tb_trigger_sequencer;

    localparam int MEW = 4;
    localparam int STN = 4;
    localparam int CNW = 16;
    localparam int SW  = 2;

    logic               clk;
    logic               rst;
    logic               ctl_arm;
    logic               ctl_abort;
    logic [STN*MEW-1:0] cfg_msk;
    logic [STN-1:0]     cfg_and;
    logic [STN*CNW-1:0] cfg_cnt;
    logic [SW-1:0]      cfg_lst;
    logic [CNW-1:0]     cfg_dly;
    logic               evt_vld;
    logic [MEW-1:0]     sti_evt;
    logic [1:0]         sts_state;
    logic [SW-1:0]      sts_stage;
    logic               trg_fire;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;
    int exp_q[$];

    trigger_sequencer #(.MEW(MEW), .STN(STN), .CNW(CNW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl_arm   (ctl_arm),
        .ctl_abort (ctl_abort),
        .cfg_msk   (cfg_msk),
        .cfg_and   (cfg_and),
        .cfg_cnt   (cfg_cnt),
        .cfg_lst   (cfg_lst),
        .cfg_dly   (cfg_dly),
        .evt_vld   (evt_vld),
        .sti_evt   (sti_evt),
        .sts_state (sts_state),
        .sts_stage (sts_stage),
        .trg_fire  (trg_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Scoreboard: every observed pulse must match the next queued edge.
    always @(negedge clk) begin
        if (trg_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fire_unexpected: got pulse at edge %0d, none expected", ecnt);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (ecnt !== e) begin
                    errors++;
                    $display("FAIL fire_edge: got %0d, want %0d", ecnt, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stage(input int s, input logic [3:0] m,
                             input logic a, input int c);
        cfg_msk[s*MEW +: MEW] = m;
        cfg_and[s]            = a;
        cfg_cnt[s*CNW +: CNW] = CNW'(c);
    endtask

    task automatic beat(input logic [3:0] e, input bit fire);
        evt_vld = 1'b1;
        sti_evt = e;
        if (fire) exp_q.push_back(ecnt + 1);
        tick();
        evt_vld = 1'b0;
        sti_evt = '0;
    endtask

    task automatic arm();
        ctl_arm = 1'b1;
        tick();
        ctl_arm = 1'b0;
    endtask

    task automatic abort();
        ctl_abort = 1'b1;
        tick();
        ctl_abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (sts_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, want 0", sts_state);
        end
        checks++;
        if (sts_stage !== 2'd0) begin
            errors++;
            $display("FAIL reset_stage: got %0d, want 0", sts_stage);
        end
        checks++;
        if (trg_fire !== 1'b0) begin
            errors++;
            $display("FAIL reset_fire: got %0b, want 0", trg_fire);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_stage();
        cfg_lst = 2'd0;
        cfg_dly = '0;
        set_stage(0, 4'b0001, 1'b0, 0);
        arm();
        checks++;
        if (sts_state !== 2'd1) begin
            errors++;
            $display("FAIL t1_armed: got %0d, want 1", sts_state);
        end
        beat(4'b0001, 1'b1);
        checks++;
        if (sts_state !== 2'd3) begin
            errors++;
            $display("FAIL t1_fired: got %0d, want 3", sts_state);
        end
        tick();
        tick();
        checks++;
        if (sts_state !== 2'd3) begin
            errors++;
            $display("FAIL t1_stay_fired: got %0d, want 3", sts_state);
        end
    endtask

    task automatic test_two_stage();
        abort();
        cfg_lst = 2'd1;
        cfg_dly = '0;
        set_stage(0, 4'b0011, 1'b0, 2);
        set_stage(1, 4'b1100, 1'b1, 0);
        arm();
        beat(4'b0001, 1'b0);
        beat(4'b0100, 1'b0);
        beat(4'b0010, 1'b0);
        checks++;
        if (sts_stage !== 2'd0) begin
            errors++;
            $display("FAIL t2_stage_hold: got %0d, want 0", sts_stage);
        end
        beat(4'b0001, 1'b0);
        checks++;
        if (sts_stage !== 2'd1) begin
            errors++;
            $display("FAIL t2_stage_adv: got %0d, want 1", sts_stage);
        end
        arm();
        beat(4'b0100, 1'b0);
        checks++;
        if (sts_state !== 2'd1 || sts_stage !== 2'd1) begin
            errors++;
            $display("FAIL t2_partial_all: got state %0d stage %0d, want 1 1",
                     sts_state, sts_stage);
        end
        beat(4'b1100, 1'b1);
        checks++;
        if (sts_state !== 2'd3) begin
            errors++;
            $display("FAIL t2_fired: got %0d, want 3", sts_state);
        end
    endtask

    task automatic test_delay_count();
        abort();
        cfg_lst = 2'd0;
        cfg_dly = CNW'(5);
        set_stage(0, 4'b0000, 1'b0, 9);
        arm();
        for (int i = 1; i <= 15; i++) begin
            beat(4'($urandom_range(0, 15)), i == 15);
            if (i == 10) begin
                checks++;
                if (sts_state !== 2'd2) begin
                    errors++;
                    $display("FAIL t3_enter_delay: got %0d, want 2", sts_state);
                end
            end
            if (i == 14) begin
                checks++;
                if (sts_state !== 2'd2) begin
                    errors++;
                    $display("FAIL t3_still_delay: got %0d, want 2", sts_state);
                end
            end
            tick();
        end
        checks++;
        if (sts_state !== 2'd3) begin
            errors++;
            $display("FAIL t3_fired: got %0d, want 3", sts_state);
        end
    endtask

    task automatic test_no_valid();
        abort();
        cfg_lst = 2'd1;
        cfg_dly = '0;
        set_stage(0, 4'b0001, 1'b0, 1);
        set_stage(1, 4'b0010, 1'b0, 0);
        arm();
        evt_vld = 1'b0;
        sti_evt = 4'b1111;
        for (int i = 0; i < 20; i++) tick();
        sti_evt = '0;
        checks++;
        if (sts_state !== 2'd1 || sts_stage !== 2'd0) begin
            errors++;
            $display("FAIL t4_idle_beats: got state %0d stage %0d, want 1 0",
                     sts_state, sts_stage);
        end
        beat(4'b0001, 1'b0);
        checks++;
        if (sts_stage !== 2'd0) begin
            errors++;
            $display("FAIL t4_hit_count: got stage %0d, want 0", sts_stage);
        end
        beat(4'b0001, 1'b0);
        beat(4'b0010, 1'b1);
        checks++;
        if (sts_state !== 2'd3) begin
            errors++;
            $display("FAIL t4_fired: got %0d, want 3", sts_state);
        end
    endtask

    task automatic test_abort();
        abort();
        cfg_lst = 2'd0;
        cfg_dly = CNW'(5);
        set_stage(0, 4'b0000, 1'b0, 0);
        arm();
        beat(4'b0000, 1'b0);
        beat(4'b0000, 1'b0);
        beat(4'b0000, 1'b0);
        checks++;
        if (sts_state !== 2'd2) begin
            errors++;
            $display("FAIL t5_in_delay: got %0d, want 2", sts_state);
        end
        abort();
        checks++;
        if (sts_state !== 2'd0 || sts_stage !== 2'd0) begin
            errors++;
            $display("FAIL t5_abort: got state %0d stage %0d, want 0 0",
                     sts_state, sts_stage);
        end
        for (int i = 0; i < 6; i++) beat(4'b0000, 1'b0);
        ctl_arm   = 1'b1;
        ctl_abort = 1'b1;
        tick();
        ctl_arm   = 1'b0;
        ctl_abort = 1'b0;
        checks++;
        if (sts_state !== 2'd0) begin
            errors++;
            $display("FAIL t5_arm_abort: got %0d, want 0", sts_state);
        end
    endtask

    task automatic test_async_reset();
        cfg_lst = 2'd3;
        cfg_dly = '0;
        set_stage(0, 4'b0000, 1'b0, 0);
        set_stage(1, 4'b0000, 1'b0, 0);
        set_stage(2, 4'b0000, 1'b0, 2);
        set_stage(3, 4'b0000, 1'b0, 0);
        arm();
        beat(4'b0000, 1'b0);
        beat(4'b0000, 1'b0);
        beat(4'b0000, 1'b0);
        checks++;
        if (sts_stage !== 2'd2) begin
            errors++;
            $display("FAIL t6_pre_stage: got %0d, want 2", sts_stage);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sts_state !== 2'd0 || sts_stage !== 2'd0 || trg_fire !== 1'b0) begin
            errors++;
            $display("FAIL t6_async_rst: got state %0d stage %0d fire %0b, want 0 0 0",
                     sts_state, sts_stage, trg_fire);
        end
        tick();
        rst = 1'b0;
        tick();
        arm();
        checks++;
        if (sts_state !== 2'd1 || sts_stage !== 2'd0) begin
            errors++;
            $display("FAIL t6_rearm: got state %0d stage %0d, want 1 0",
                     sts_state, sts_stage);
        end
        beat(4'b0000, 1'b0);
        beat(4'b0000, 1'b0);
        beat(4'b0000, 1'b0);
        beat(4'b0000, 1'b0);
        beat(4'b0000, 1'b0);
        checks++;
        if (sts_stage !== 2'd3 || sts_state !== 2'd1) begin
            errors++;
            $display("FAIL t6_stage3: got state %0d stage %0d, want 1 3",
                     sts_state, sts_stage);
        end
        beat(4'b0000, 1'b1);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        ctl_arm   = 1'b0;
        ctl_abort = 1'b0;
        cfg_msk   = '0;
        cfg_and   = '0;
        cfg_cnt   = '0;
        cfg_lst   = '0;
        cfg_dly   = '0;
        evt_vld   = 1'b0;
        sti_evt   = '0;
        test_reset();
        test_single_stage();
        test_two_stage();
        test_delay_count();
        test_no_valid();
        test_abort();
        test_async_reset();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL fire_missing: %0d pulses outstanding, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
